// File: rtl/locked_reg_pkg.sv
// Shared types and helpers for the lockable configuration register bank.
package locked_reg_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        LOCKED = 2'd1,
        RANGE  = 2'd2
    } viol_cause_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/locked_reg_bank.sv
// Bank of sticky-lockable config registers with violation logging.
module locked_reg_bank
    import locked_reg_pkg::*;
#(
    parameter int               WIDTH          = 16,
    parameter int               NUM_REGS       = 4,
    parameter int               AW             = clog2_min1(NUM_REGS),
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter bit               DEBUG_OVERRIDE = 1'b1,
    parameter int               CNT_W          = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [NUM_REGS-1:0]       lock_set,
    input  logic                      debug_unlocked,
    input  logic                      rd_en,
    input  logic [AW-1:0]             rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic [NUM_REGS*WIDTH-1:0] data_out,
    output logic [NUM_REGS-1:0]       lock_status,
    output logic                      viol_flag,
    output logic [CNT_W-1:0]          viol_count,
    output logic [AW-1:0]             viol_addr,
    output viol_cause_t               viol_cause
);

    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0] lock_q;
    logic [NUM_REGS-1:0] lock_eff;
    logic [NUM_REGS-1:0] wr_sel;
    logic                range_err;
    logic                lock_hit;
    logic                bypass;
    logic                wr_ok;
    logic                viol;
    viol_cause_t         cause;
    logic [WIDTH-1:0]    rd_mux;

    // A lock requested this cycle already guards the same-cycle write.
    assign lock_eff = lock_q | lock_set;
    assign bypass   = DEBUG_OVERRIDE && debug_unlocked;

    always_comb begin
        wr_sel    = '0;
        range_err = 1'b1;
        lock_hit  = 1'b0;
        rd_mux    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == AW'(i)) begin
                wr_sel[i] = 1'b1;
                range_err = 1'b0;
                lock_hit  = lock_eff[i];
            end
            if (rd_addr == AW'(i)) begin
                rd_mux = regs[i];
            end
        end
    end

    assign viol  = wr_en && (range_err || (lock_hit && !bypass));
    assign wr_ok = wr_en && !viol;
    assign cause = range_err ? RANGE : LOCKED;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            lock_q <= '0;
        end else begin
            lock_q <= lock_q | lock_set;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && wr_sel[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            viol_flag  <= 1'b0;
            viol_addr  <= '0;
            viol_cause <= NONE;
        end else if (viol) begin
            viol_flag  <= 1'b1;
            viol_addr  <= wr_addr;
            viol_cause <= cause;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_viol_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (viol),
        .count  (viol_count)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign data_out[g*WIDTH +: WIDTH] = regs[g];
    end

    assign lock_status = lock_q;

endmodule
